xor_parity_stream: RTL and testbench
====================================

Name: xor_parity_stream

Overview:
- Serial even-parity accumulator that sits directly upstream of the two-input XOR stage.
- Folds a stream of single bits through a registered XOR feedback loop, one bit per accepted beat.
- Emits the parity of each fixed-length frame on a valid/ready output port.
- Keeps a saturating count of completed frames.

Parameters:
- FRAME_LEN, 8: data bits per frame; legal range 2..255.
- CNT_W, 8: width of the internal bit counter; must satisfy 2^CNT_W > FRAME_LEN.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset.
- in_valid  input  1  upstream bit is valid this cycle.
- in_ready  output  1  block can accept a bit this cycle.
- in_bit  input  1  serial data bit.
- out_valid  output  1  frame parity result is valid.
- out_ready  input  1  downstream accepts the result.
- out_parity  output  1  XOR of all data bits of the frame (even parity bit).
- frame_cnt  output  16  number of frames handed off; saturates at 16'hFFFF.
- parity_err  output  1  present only with XOR_PARITY_CHECK_EN.

Interface (already decided):
- One clock: clk.
- Reset rst_n is asynchronous and active-low.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, acc=0, bit count=0.
  - out_valid=0, out_parity=0, frame_cnt=0, parity_err=0.
  - in_ready=1 combinationally, since it is derived from state.
- Input transfer occurs when in_valid && in_ready at a rising clk edge.
- in_ready = 1 in IDLE and ACCUM, 0 in HOLD.
- in_valid low: no state change. Gaps of any length are legal mid-frame.
- IDLE:
  - On transfer: acc<=in_bit, count<=1, go to ACCUM.
  - No transfer: stay in IDLE.
- ACCUM:
  - On transfer: acc<=acc^in_bit, count<=count+1.
  - When the accepted bit is the last bit of the frame (count==FRAME_LEN-1 before the edge):
    - out_parity<=acc^in_bit, out_valid<=1.
    - acc<=0, count<=0, go to HOLD.
- HOLD:
  - out_valid=1. out_parity (and parity_err) are held stable.
  - in_bit and in_valid are ignored.
  - On out_ready=1: out_valid<=0, frame_cnt<=frame_cnt+1 (no increment at 16'hFFFF), go to IDLE.
- Latency: out_valid rises on the edge that accepts the last frame bit, so it is visible the following cycle.
- Throughput: minimum FRAME_LEN+1 cycles per frame with in_valid and out_ready held high. The HOLD→IDLE cycle is mandatory.
- Parity rule: out_parity=1 iff the frame contains an odd number of ones.
- All outputs except in_ready are registered. No combinational path from out_ready to in_ready.
- Reset mid-frame: the partial frame is discarded. The next accepted bit starts a fresh frame.
- Reset during HOLD: the pending result is lost and frame_cnt clears.
- Reset during IDLE or ACCUM: frame_cnt also clears, since reset clears it in all states.

Optional Feature:
XOR_PARITY_CHECK_EN
- Defined:
  - A frame is FRAME_LEN data bits followed by one received-parity bit. ACCUM accepts FRAME_LEN+1 bits.
  - The final bit is not folded into out_parity.
  - On that final transfer: out_parity<=data parity, parity_err<=data parity ^ received bit, out_valid<=1.
  - parity_err holds with out_parity during HOLD and is updated only at the next frame completion.
  - Counter range is FRAME_LEN+1, so 2^CNT_W > FRAME_LEN+1 is required.
- Undefined:
  - The parity_err port does not exist.
  - A frame is exactly FRAME_LEN bits.

Test Plan:
1. Reset: assert rst_n=0 mid-cycle → out_valid=0, out_parity=0, frame_cnt=0, in_ready=1 immediately, without waiting for a clock edge.
2. FRAME_LEN=8, out_ready=1, back-to-back bits 1,0,1,1,0,0,0,0 → out_valid=1 one cycle after the 8th accept, out_parity=1. Next cycle frame_cnt=1 and in_ready=1.
3. Bits 1,1,0,0,1,1,0,0 with in_valid low for 3 cycles between each bit → out_parity=0 after 8 accepted bits. Gaps do not affect the count.
4. Backpressure: complete a frame with out_ready=0 for 5 cycles while toggling in_bit/in_valid → in_ready=0, out_valid and out_parity stable, frame_cnt unchanged. On out_ready=1, frame_cnt increments once.
5. Reset mid-frame: accept 4 bits, pulse rst_n low, then send 8 ones → out_parity=0 and frame_cnt=1. The partial frame is discarded.
6. With XOR_PARITY_CHECK_EN:
   - Data 1,0,0,0,0,0,0,0 + check bit 0 → out_parity=1, parity_err=1.
   - Repeat with check bit 1 → parity_err=0.

Source files
------------

// File: rtl/xor_parity_stream_if.sv
// Handshake bundle for xor_parity_stream: serial bit input and frame-parity output.
// parity_err exists only when XOR_PARITY_CHECK_EN is defined.
interface xor_parity_stream_if;
   logic        in_valid;
   logic        in_ready;
   logic        in_bit;
   logic        out_valid;
   logic        out_ready;
   logic        out_parity;
   logic [15:0] frame_cnt;
`ifdef XOR_PARITY_CHECK_EN
   logic        parity_err;
`endif

   modport master (
      output in_valid, in_bit, out_ready,
      input  in_ready, out_valid, out_parity, frame_cnt
`ifdef XOR_PARITY_CHECK_EN
      , input parity_err
`endif
   );

   modport slave (
      input  in_valid, in_bit, out_ready,
      output in_ready, out_valid, out_parity, frame_cnt
`ifdef XOR_PARITY_CHECK_EN
      , output parity_err
`endif
   );
endinterface

// File: rtl/xor_parity_stream.sv
// Serial even-parity accumulator: folds FRAME_LEN bits per frame, hands the parity off on valid/ready.
// Define XOR_PARITY_CHECK_EN to append a received-parity bit per frame and report parity_err.
module xor_parity_stream #(
   parameter int FRAME_LEN = 8,
   parameter int CNT_W     = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   xor_parity_stream_if.slave    bus
);

`ifdef XOR_PARITY_CHECK_EN
   localparam int LAST_IDX = FRAME_LEN;
`else
   localparam int LAST_IDX = FRAME_LEN - 1;
`endif
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LAST_IDX);

   typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

   state_t            state_reg, state_next;
   logic              acc_reg, acc_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic              valid_reg, valid_next;
   logic              parity_reg, parity_next;
   logic [15:0]       frame_cnt_reg, frame_cnt_next;
   logic              in_ready_int;
   logic              accept;
`ifdef XOR_PARITY_CHECK_EN
   logic              err_reg, err_next;
`endif

   // in_ready depends only on state, so out_ready never reaches it combinationally.
   assign in_ready_int = (state_reg != HOLD);
   assign accept       = bus.in_valid && in_ready_int;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         acc_reg       <= 1'b0;
         cnt_reg       <= '0;
         valid_reg     <= 1'b0;
         parity_reg    <= 1'b0;
         frame_cnt_reg <= '0;
`ifdef XOR_PARITY_CHECK_EN
         err_reg       <= 1'b0;
`endif
      end else begin
         state_reg     <= state_next;
         acc_reg       <= acc_next;
         cnt_reg       <= cnt_next;
         valid_reg     <= valid_next;
         parity_reg    <= parity_next;
         frame_cnt_reg <= frame_cnt_next;
`ifdef XOR_PARITY_CHECK_EN
         err_reg       <= err_next;
`endif
      end
   end

   always_comb begin
      state_next     = state_reg;
      acc_next       = acc_reg;
      cnt_next       = cnt_reg;
      valid_next     = valid_reg;
      parity_next    = parity_reg;
      frame_cnt_next = frame_cnt_reg;
`ifdef XOR_PARITY_CHECK_EN
      err_next       = err_reg;
`endif
      case (state_reg)
         IDLE: begin
            if (accept) begin
               acc_next   = bus.in_bit;
               cnt_next   = CNT_W'(1);
               state_next = ACCUM;
            end
         end
         ACCUM: begin
            if (accept) begin
               if (cnt_reg == LAST_CNT) begin
`ifdef XOR_PARITY_CHECK_EN
                  // Final bit is the received parity: compare, do not fold.
                  parity_next = acc_reg;
                  err_next    = acc_reg ^ bus.in_bit;
`else
                  parity_next = acc_reg ^ bus.in_bit;
`endif
                  valid_next  = 1'b1;
                  acc_next    = 1'b0;
                  cnt_next    = '0;
                  state_next  = HOLD;
               end else begin
                  acc_next = acc_reg ^ bus.in_bit;
                  cnt_next = cnt_reg + 1'b1;
               end
            end
         end
         HOLD: begin
            if (bus.out_ready) begin
               valid_next = 1'b0;
               if (frame_cnt_reg != 16'hFFFF)
                  frame_cnt_next = frame_cnt_reg + 16'd1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign bus.in_ready   = in_ready_int;
   assign bus.out_valid  = valid_reg;
   assign bus.out_parity = parity_reg;
   assign bus.frame_cnt  = frame_cnt_reg;
`ifdef XOR_PARITY_CHECK_EN
   assign bus.parity_err = err_reg;
`endif

endmodule

// File: tb/tb_xor_parity_stream.sv
// Scoreboard bench for xor_parity_stream (FRAME_LEN=8): directed frames, decoupled output monitor.
module tb_xor_parity_stream;
   localparam int FL = 8;

   logic clk;
   logic rst_n;
   xor_parity_stream_if bus();

   int n_checks = 0;
   int n_fail   = 0;
   logic [1:0] exp_q[$];

   xor_parity_stream #(.FRAME_LEN(FL), .CNT_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: pops one expected result per output handshake.
   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         logic [1:0] e;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output: parity %0b with empty scoreboard at %0t", bus.out_parity, $time);
         end else begin
            e = exp_q.pop_front();
            check("out_parity", {15'd0, bus.out_parity}, {15'd0, e[1]});
`ifdef XOR_PARITY_CHECK_EN
            check("parity_err", {15'd0, bus.parity_err}, {15'd0, e[0]});
`endif
            $display("frame out: parity=%0b expected=%0b frame_cnt=%0d", bus.out_parity, e[1], bus.frame_cnt);
         end
      end
   end

   task automatic send_bit(input logic b);
      int t = 0;
      bus.in_valid = 1'b1;
      bus.in_bit   = b;
      while (!bus.in_ready && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      if (!bus.in_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL in_ready_timeout: in_ready stayed 0, expected 1 at %0t", $time);
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   // Data bits are sent leftmost first; expected results are hand-computed by the caller.
   task automatic send_frame(input logic [FL-1:0] d, input logic exp_par, input int gap,
                             input logic chk, input logic exp_err);
      exp_q.push_back({exp_par, exp_err});
      for (int i = 0; i < FL; i++) begin
         send_bit(d[FL-1-i]);
         if (i != FL - 1 || gap != 0) repeat (gap) @(posedge clk);
         if (gap != 0) #1;
      end
`ifdef XOR_PARITY_CHECK_EN
      send_bit(chk);
`endif
      $display("frame in: data=%b chk=%0b gap=%0d", d, chk, gap);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation still running at %0t, expected finish", $time);
      $fatal(1, "timeout");
   end

   initial begin
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_bit    = 1'b0;
      bus.out_ready = 1'b1;
      #2;
      check("rst_in_ready",   {15'd0, bus.in_ready},   16'd1);
      check("rst_out_valid",  {15'd0, bus.out_valid},  16'd0);
      check("rst_out_parity", {15'd0, bus.out_parity}, 16'd0);
      check("rst_frame_cnt",  bus.frame_cnt,           16'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Back-to-back frame, parity 1, result visible the cycle after the last accept.
      send_frame(8'b10110000, 1'b1, 0, 1'b1, 1'b0);
      check("t2_out_valid", {15'd0, bus.out_valid}, 16'd1);
      check("t2_in_ready_hold", {15'd0, bus.in_ready}, 16'd0);
      @(posedge clk); #1;
      check("t2_frame_cnt", bus.frame_cnt, 16'd1);
      check("t2_in_ready", {15'd0, bus.in_ready}, 16'd1);
      check("t2_valid_clr", {15'd0, bus.out_valid}, 16'd0);

      // Gapped input, parity 0.
      send_frame(8'b11001100, 1'b0, 3, 1'b0, 1'b0);
      @(posedge clk); #1;
      check("t3_frame_cnt", bus.frame_cnt, 16'd2);

      // Backpressure: HOLD keeps everything stable while inputs toggle.
      bus.out_ready = 1'b0;
      send_frame(8'b11100000, 1'b1, 0, 1'b1, 1'b0);
      for (int k = 0; k < 5; k++) begin
         bus.in_valid = k[0];
         bus.in_bit   = ~k[1];
         @(posedge clk); #1;
         check("t4_in_ready",  {15'd0, bus.in_ready},   16'd0);
         check("t4_out_valid", {15'd0, bus.out_valid},  16'd1);
         check("t4_parity",    {15'd0, bus.out_parity}, 16'd1);
         check("t4_frame_cnt", bus.frame_cnt,           16'd2);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      check("t4_frame_cnt_inc", bus.frame_cnt, 16'd3);
      check("t4_valid_clr", {15'd0, bus.out_valid}, 16'd0);
      @(posedge clk); #1;
      check("t4_frame_cnt_once", bus.frame_cnt, 16'd3);

      // Reset mid-frame, asserted between edges; partial frame discarded.
      send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
      #3 rst_n = 1'b0;
      #1;
      check("t5_rst_frame_cnt", bus.frame_cnt, 16'd0);
      check("t5_rst_in_ready", {15'd0, bus.in_ready}, 16'd1);
      check("t5_rst_out_valid", {15'd0, bus.out_valid}, 16'd0);
      #1 rst_n = 1'b1;
      send_frame(8'b11111111, 1'b0, 0, 1'b0, 1'b0);
      check("t5_out_valid", {15'd0, bus.out_valid}, 16'd1);
      @(posedge clk); #1;
      check("t5_frame_cnt", bus.frame_cnt, 16'd1);

`ifdef XOR_PARITY_CHECK_EN
      // Received-parity check: wrong check bit then correct one.
      send_frame(8'b10000000, 1'b1, 0, 1'b0, 1'b1);
      check("t6_err_set", {15'd0, bus.parity_err}, 16'd1);
      @(posedge clk); #1;
      send_frame(8'b10000000, 1'b1, 0, 1'b1, 1'b0);
      check("t6_err_clr", {15'd0, bus.parity_err}, 16'd0);
      @(posedge clk); #1;
      check("t6_frame_cnt", bus.frame_cnt, 16'd3);
`endif

      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_empty", 16'(exp_q.size()), 16'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
